// File: rtl/maxil_pkg.sv
// maxil_pkg: state encoding and AXI response codes shared by the AXI-Lite read master
package maxil_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR = 2'd1;
  localparam logic [1:0] ST_R = 2'd2;
  localparam logic [1:0] ST_RSP = 2'd3;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/maxil_read_top.sv
// maxil_read_top: AXI4-Lite read master, one outstanding read; MAXIL_READ_ALIGN_CHECK_EN rejects unaligned addresses locally
module maxil_read_top
  import maxil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W = 16
) (
  input  logic              maxil_read_top_clk,
  input  logic              maxil_read_top_rst,
  input  logic              maxil_read_cmd_valid,
  output logic              maxil_read_cmd_ready,
  input  logic [ADDR_W-1:0] maxil_read_cmd_addr,
  input  logic [2:0]        maxil_read_cmd_prot,
  output logic              maxil_read_arvalid,
  input  logic              maxil_read_arready,
  output logic [ADDR_W-1:0] maxil_read_araddr,
  output logic [2:0]        maxil_read_arprot,
  input  logic              maxil_read_rvalid,
  output logic              maxil_read_rready,
  input  logic [DATA_W-1:0] maxil_read_rdata,
  input  logic [1:0]        maxil_read_rresp,
  output logic              maxil_read_rsp_valid,
  input  logic              maxil_read_rsp_ready,
  output logic [DATA_W-1:0] maxil_read_rsp_data,
  output logic [1:0]        maxil_read_rsp_resp,
  output logic [CNT_W-1:0]  maxil_read_rd_count,
  output logic [CNT_W-1:0]  maxil_read_err_count
);
  logic [1:0] state;
  logic misalign;
  assign maxil_read_cmd_ready = state == ST_IDLE;
  assign maxil_read_arvalid = state == ST_AR;
  assign maxil_read_rready = state == ST_R;
  assign maxil_read_rsp_valid = state == ST_RSP;
`ifdef MAXIL_READ_ALIGN_CHECK_EN
  assign misalign = |(maxil_read_cmd_addr & ADDR_W'(DATA_W / 8 - 1));
`else
  assign misalign = 1'b0;
`endif
  always_ff @(posedge maxil_read_top_clk)
    if (maxil_read_top_rst) begin
      state <= ST_IDLE;
      maxil_read_araddr <= '0;
      maxil_read_arprot <= '0;
      maxil_read_rsp_data <= '0;
      maxil_read_rsp_resp <= '0;
      maxil_read_rd_count <= '0;
      maxil_read_err_count <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (maxil_read_cmd_valid) begin
            maxil_read_araddr <= maxil_read_cmd_addr;
            maxil_read_arprot <= maxil_read_cmd_prot;
            maxil_read_rsp_data <= '0;
            maxil_read_rsp_resp <= RESP_SLVERR;
            state <= misalign ? ST_RSP : ST_AR;
          end
        ST_AR: if (maxil_read_arready) state <= ST_R;
        ST_R:
          if (maxil_read_rvalid) begin
            maxil_read_rsp_data <= maxil_read_rdata;
            maxil_read_rsp_resp <= maxil_read_rresp;
            state <= ST_RSP;
          end
        default:
          if (maxil_read_rsp_ready) begin
            maxil_read_rd_count <= maxil_read_rd_count + CNT_W'(1);
            maxil_read_err_count <= maxil_read_err_count + CNT_W'(maxil_read_rsp_resp[1]);
            state <= ST_IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_maxil_read_top.sv
// tb_maxil_read_top: transaction-level checks of the AXI-Lite read master against a simple slave and counter model
module tb_maxil_read_top;
  localparam int AW = 32, DW = 32, CW = 16;
`ifdef MAXIL_READ_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0, araddr;
  logic [2:0] cmd_prot = '0, arprot;
  logic arvalid, arready = 1'b0, rvalid = 1'b0, rready, rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rdata = '0, rsp_data;
  logic [1:0] rresp = '0, rsp_resp;
  logic [CW-1:0] rd_count, err_count;
  int compared = 0, mismatched = 0;
  logic [CW-1:0] m_rd = '0, m_err = '0;

  maxil_read_top #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .maxil_read_top_clk(clk), .maxil_read_top_rst(rst),
    .maxil_read_cmd_valid(cmd_valid), .maxil_read_cmd_ready(cmd_ready),
    .maxil_read_cmd_addr(cmd_addr), .maxil_read_cmd_prot(cmd_prot),
    .maxil_read_arvalid(arvalid), .maxil_read_arready(arready),
    .maxil_read_araddr(araddr), .maxil_read_arprot(arprot),
    .maxil_read_rvalid(rvalid), .maxil_read_rready(rready),
    .maxil_read_rdata(rdata), .maxil_read_rresp(rresp),
    .maxil_read_rsp_valid(rsp_valid), .maxil_read_rsp_ready(rsp_ready),
    .maxil_read_rsp_data(rsp_data), .maxil_read_rsp_resp(rsp_resp),
    .maxil_read_rd_count(rd_count), .maxil_read_err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full read: arw cycles of arready low, rw cycles of rvalid low, rspw cycles of rsp_ready low
  task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int arw, input int rw,
                         input int rspw, input logic [31:0] d, input logic [1:0] r);
    logic mis;
    logic [1:0] er;
    logic [31:0] ed;
    mis = ALIGN && (a[1:0] != 2'b00);
    er = mis ? 2'b10 : r;
    ed = mis ? 32'h0 : d;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_prot = p;
    tick;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_prot = 3'($urandom);
    chk("cmd_ready_busy", cmd_ready, 0);
    if (!mis) begin
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, a);
      chk("arprot", arprot, p);
      for (int i = 0; i < arw; i++) begin
        arready = 1'b0; rvalid = 1'b1; rdata = $urandom;
        tick;
        chk("arvalid_hold", arvalid, 1);
        chk("araddr_hold", araddr, a);
        chk("rready_in_ar", rready, 0);
      end
      arready = 1'b1; rvalid = 1'b0;
      tick;
      arready = 1'b0;
      chk("arvalid_drop", arvalid, 0);
      chk("rready", rready, 1);
      for (int i = 0; i < rw; i++) begin
        tick;
        chk("rready_wait", rready, 1);
        chk("rsp_valid_early", rsp_valid, 0);
      end
      rvalid = 1'b1; rdata = d; rresp = r;
      tick;
      rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
      chk("rready_after", rready, 0);
    end else
      chk("no_arvalid", arvalid, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_resp", rsp_resp, er);
    for (int i = 0; i < rspw; i++) begin
      tick;
      chk("rsp_valid_hold", rsp_valid, 1);
      chk("rsp_data_hold", rsp_data, ed);
      chk("rsp_resp_hold", rsp_resp, er);
      chk("cmd_ready_rsp", cmd_ready, 0);
      chk("rd_count_hold", rd_count, m_rd);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    m_rd = m_rd + 1'b1;
    m_err = m_err + CW'(er[1]);
    chk("rsp_valid_done", rsp_valid, 0);
    chk("cmd_ready_after", cmd_ready, 1);
    chk("rd_count", rd_count, m_rd);
    chk("err_count", err_count, m_err);
  endtask

  initial begin
    tick;
    tick;
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rd_count", rd_count, 0);
    do_read(32'hFFFF_FFFC, 3'd0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);
    do_read(32'h1234_5670, 3'd5, 5, 0, 0, 32'h0BAD_F00D, 2'b00);
    do_read(32'hF0F0_F0F0, 3'd2, 0, 4, 0, 32'h5555_AAAA, 2'b10);
    do_read(32'h0000_1000, 3'd7, 1, 1, 3, 32'hCAFE_0001, 2'b00);
    do_read(32'h0000_2004, 3'd1, 0, 0, 0, 32'h0000_0E0E, 2'b01);
    do_read(32'h0000_3008, 3'd3, 0, 0, 1, 32'hDEC0_DE00, 2'b11);
    do_read(32'h0000_0002, 3'd4, 0, 0, 0, 32'h7777_7777, 2'b00);
    // abandon a read in R via reset
    cmd_valid = 1'b1; cmd_addr = 32'h0000_4000; cmd_prot = 3'd6;
    tick;
    cmd_valid = 1'b0; arready = 1'b1;
    tick;
    arready = 1'b0;
    chk("pre_rst_rready", rready, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_rd = '0; m_err = '0;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_araddr", araddr, 0);
    chk("mid_rst_arprot", arprot, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_rsp_resp", rsp_resp, 0);
    chk("mid_rst_rd_count", rd_count, 0);
    chk("mid_rst_err_count", err_count, 0);
    rvalid = 1'b1; rdata = 32'h1111_1111;
    tick;
    rvalid = 1'b0;
    chk("stray_rvalid_ignored", rsp_valid, 0);
    for (int n = 0; n < 40; n++)
      do_read($urandom, 3'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), $urandom, 2'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
